// File: rtl/gate_lab_pkg.sv
// Shared mode encoding for gate_lab. GATE_LAB_XNOR_EN adds a sixth mode (XNOR)
// and moves the wrap point to it.
package gate_lab_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_NAND = 3'd0,
    MODE_NOT  = 3'd1,
    MODE_AND  = 3'd2,
    MODE_OR   = 3'd3,
    MODE_XOR  = 3'd4
`ifdef GATE_LAB_XNOR_EN
    , MODE_XNOR = 3'd5
`endif
  } mode_e;

`ifdef GATE_LAB_XNOR_EN
  localparam mode_e MODE_LAST = MODE_XNOR;
`else
  localparam mode_e MODE_LAST = MODE_XOR;
`endif

  // Anything at or past the last legal code (including SEU-corrupted codes) wraps to 0.
  function automatic logic [MODE_W-1:0] mode_next(input logic [MODE_W-1:0] m);
    return (m >= MODE_LAST) ? '0 : m + 1'b1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, consecutive-cycle debounce counter
// and a one-cycle pulse on each rising edge of the accepted level.
module btn_debounce #(
  parameter int DB_CYCLES = 65536
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic in,
  output logic level,
  output logic rise
);

  localparam int CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             stable_q, stable_d;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter tracks how long the synced input has disagreed with the accepted level.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (s2_q != stable_q) begin
      if (cnt_q == CNT_LAST) stable_d = s2_q;
      else                   cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      prev_q   <= 1'b0;
    end else begin
      s1_q     <= in;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      prev_q   <= stable_q;
    end
  end

  assign level = stable_q;
  assign rise  = stable_q & ~prev_q;

endmodule

// File: rtl/gate_lab.sv
// Run-time selectable WIDTH-bit logic unit with PWM-dimmed LED output.
// Define GATE_LAB_XNOR_EN to add XNOR as mode 5.
module gate_lab
  import gate_lab_pkg::*;
#(
  parameter int WIDTH     = 2,
  parameter int DB_CYCLES = 65536,
  parameter int PWM_BITS  = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [WIDTH-1:0]    A,
  input  logic [WIDTH-1:0]    B,
  input  logic                MODE_BTN,
  input  logic [PWM_BITS-1:0] DUTY,
  output logic [WIDTH-1:0]    LED,
  output logic [MODE_W-1:0]   MODE
);

  logic [1:0][WIDTH-1:0] a_sync_q, b_sync_q;
  logic [MODE_W-1:0]     mode_q, mode_d;
  logic [WIDTH-1:0]      result_q, result_d;
  logic [WIDTH-1:0]      led_q, led_d;
  logic [PWM_BITS-1:0]   pwm_cnt_q;
  logic                  pwm_on;
  logic                  btn_rise;
  logic                  btn_level_unused;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_mode_btn (
    .CLK   (CLK),
    .RST_N (RST_N),
    .in    (MODE_BTN),
    .level (btn_level_unused),
    .rise  (btn_rise)
  );

  assign mode_d = btn_rise ? mode_next(mode_q) : mode_q;

  // Uses the registered mode, so a simultaneous mode/operand change never mixes.
  always_comb begin
    result_d = ~(a_sync_q[1] & b_sync_q[1]);
    case (mode_e'(mode_q))
      MODE_NOT:  result_d = ~a_sync_q[1];
      MODE_AND:  result_d = a_sync_q[1] & b_sync_q[1];
      MODE_OR:   result_d = a_sync_q[1] | b_sync_q[1];
      MODE_XOR:  result_d = a_sync_q[1] ^ b_sync_q[1];
`ifdef GATE_LAB_XNOR_EN
      MODE_XNOR: result_d = ~(a_sync_q[1] ^ b_sync_q[1]);
`endif
      default:   result_d = ~(a_sync_q[1] & b_sync_q[1]);
    endcase
  end

  assign pwm_on = (pwm_cnt_q < DUTY);
  assign led_d  = result_q & {WIDTH{pwm_on}};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_sync_q  <= '0;
      b_sync_q  <= '0;
      mode_q    <= '0;
      result_q  <= '0;
      led_q     <= '0;
      pwm_cnt_q <= '0;
    end else begin
      a_sync_q  <= {a_sync_q[0], A};
      b_sync_q  <= {b_sync_q[0], B};
      mode_q    <= mode_d;
      result_q  <= result_d;
      led_q     <= led_d;
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
    end
  end

  assign LED  = led_q;
  assign MODE = mode_q;

endmodule

// File: tb/tb_gate_lab.sv
// Randomised + directed bench for gate_lab with a history-based reference model
// feeding a scoreboard queue that a negedge monitor drains.
module tb_gate_lab;

  localparam int W  = 2;
  localparam int DB = 4;
  localparam int PB = 4;
`ifdef GATE_LAB_XNOR_EN
  localparam int NM = 6;
`else
  localparam int NM = 5;
`endif

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [W-1:0]  A, B;
  logic          MODE_BTN;
  logic [PB-1:0] DUTY;
  logic [W-1:0]  LED;
  logic [2:0]    MODE;

  int checks = 0;
  int errors = 0;

  gate_lab #(.WIDTH(W), .DB_CYCLES(DB), .PWM_BITS(PB)) dut (
    .CLK(CLK), .RST_N(RST_N), .A(A), .B(B), .MODE_BTN(MODE_BTN),
    .DUTY(DUTY), .LED(LED), .MODE(MODE)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [W-1:0] led; logic [2:0] mode; } exp_t;
  exp_t exp_q[$];

  // Reference model: edge-indexed input histories since the last reset.
  int          n;
  logic [W-1:0] ah[$], bh[$];
  logic        bth[$];
  logic        st_h[$];
  int          run;
  int          m_mode;
  logic [W-1:0] m_res, m_led;

  function automatic logic [W-1:0] op(input int m, input logic [W-1:0] a, input logic [W-1:0] b);
    case (m)
      1: return ~a;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return ~(a ^ b);
      default: return ~(a & b);
    endcase
  endfunction

  always @(posedge CLK) begin
    exp_t e;
    if (!RST_N) begin
      n = 0; run = 0; m_mode = 0; m_res = '0; m_led = '0;
      ah.delete(); bh.delete(); bth.delete(); st_h.delete();
      st_h.push_back(1'b0);
    end else begin
      logic [W-1:0] sa, sb, new_res, new_led;
      logic         sbtn, new_st;
      int           new_mode;
      n++;
      ah.push_back(A); bh.push_back(B); bth.push_back(MODE_BTN);
      // core logic sees the input that was sampled two edges earlier
      sa   = (n >= 3) ? ah[n-3]  : '0;
      sb   = (n >= 3) ? bh[n-3]  : '0;
      sbtn = (n >= 3) ? bth[n-3] : 1'b0;
      new_st = st_h[n-1];
      if (sbtn != st_h[n-1]) begin
        run++;
        if (run == DB) begin new_st = sbtn; run = 0; end
      end else run = 0;
      new_mode = m_mode;
      if (n >= 2 && st_h[n-1] && !st_h[n-2]) new_mode = (m_mode >= NM-1) ? 0 : m_mode + 1;
      new_res = op(m_mode, sa, sb);
      new_led = (((n-1) % (1 << PB)) < int'(DUTY)) ? m_res : '0;
      m_mode = new_mode; m_res = new_res; m_led = new_led;
      st_h.push_back(new_st);
    end
    e.led = m_led; e.mode = 3'(m_mode);
    exp_q.push_back(e);
  end

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (LED !== e.led || MODE !== e.mode) begin
        errors++;
        $display("FAIL scoreboard t=%0t LED=%0d MODE=%0d expected LED=%0d MODE=%0d",
                 $time, LED, MODE, e.led, e.mode);
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  task automatic count_changes(input int ncyc, output int nchg, output int first);
    logic [2:0] prev;
    prev = MODE; nchg = 0; first = 0;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge CLK); @(negedge CLK);
      if (MODE !== prev) begin
        nchg++;
        if (first == 0) first = k;
        prev = MODE;
      end
    end
  endtask

  task automatic press();
    MODE_BTN = 1'b1;
    repeat (DB + 6) @(negedge CLK);
    MODE_BTN = 1'b0;
    repeat (DB + 6) @(negedge CLK);
  endtask

  task automatic goto_mode(input int m);
    int guard = 0;
    while (m_mode != m && guard < NM + 2) begin press(); guard++; end
    chk("goto_mode", m_mode, m);
  endtask

  task automatic led_stats(input int ncyc, output int or_val, output int cnt3);
    or_val = 0; cnt3 = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge CLK);
      or_val = or_val | int'(LED);
      if (LED == 2'd3) cnt3++;
    end
  endtask

  initial begin
    int nchg, first, orv, c3, m0;
    RST_N = 1'b0; A = 2'd3; B = 2'd3; MODE_BTN = 1'b1; DUTY = 4'd15;
    repeat (3) @(negedge CLK);
    chk("reset_led", int'(LED), 0);
    chk("reset_mode", int'(MODE), 0);
    RST_N = 1'b1;
    count_changes(14, nchg, first);
    chk("rst_held_advances", nchg, 1);
    chk("rst_held_edge", first, 7);
    chk("rst_held_mode", int'(MODE), 1);
    MODE_BTN = 1'b0;
    repeat (12) @(negedge CLK);

    // truth table sweep, every cycle checked by the scoreboard
    for (int m = 0; m < NM; m++) begin
      goto_mode(m);
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 4; b++) begin
          A = 2'(a); B = 2'(b);
          repeat (5) @(negedge CLK);
        end
    end
    goto_mode(4); A = 2'd2; B = 2'd3; repeat (6) @(negedge CLK);
    led_stats(16, orv, c3);
    chk("xor_2_3", orv, 1);
    goto_mode(1); A = 2'd1; B = 2'($urandom); repeat (6) @(negedge CLK);
    led_stats(16, orv, c3);
    chk("not_1", orv, 2);
`ifdef GATE_LAB_XNOR_EN
    goto_mode(5); A = 2'd1; B = 2'd1; repeat (6) @(negedge CLK);
    led_stats(16, orv, c3);
    chk("xnor_1_1", orv, 3);
`endif

    // wrap
    goto_mode(0);
    for (int i = 0; i < NM; i++) begin
      press();
      chk("wrap_mode", int'(MODE), (i + 1) % NM);
    end

    // bounce
    m0 = m_mode;
    for (int i = 0; i < 5; i++) begin
      MODE_BTN = 1'b1; repeat (2) @(negedge CLK);
      MODE_BTN = 1'b0; repeat (2) @(negedge CLK);
    end
    chk("bounce_no_advance", int'(MODE), m0);
    MODE_BTN = 1'b1;
    count_changes(14, nchg, first);
    chk("bounce_advances", nchg, 1);
    chk("bounce_edge", first, 7);
    MODE_BTN = 1'b0;
    repeat (12) @(negedge CLK);

    // PWM duty
    goto_mode(3); A = 2'd3; B = 2'd0;
    DUTY = 4'd0; repeat (8) @(negedge CLK);
    led_stats(32, orv, c3);
    chk("duty0_or", orv, 0);
    DUTY = 4'd4; repeat (4) @(negedge CLK);
    led_stats(16, orv, c3);
    chk("duty4_on", c3, 4);
    DUTY = 4'd15; repeat (4) @(negedge CLK);
    led_stats(16, orv, c3);
    chk("duty15_on", c3, 15);

    // mid-operation reset with debounce counter at 2
    goto_mode(3);
    MODE_BTN = 1'b1;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("midrst_mode", int'(MODE), 0);
    chk("midrst_led", int'(LED), 0);
    MODE_BTN = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    count_changes(20, nchg, first);
    chk("midrst_no_advance", nchg, 0);

    // random soak
    for (int i = 0; i < 600; i++) begin
      A = 2'($urandom); B = 2'($urandom);
      if ($urandom_range(0, 19) == 0) DUTY = 4'($urandom);
      if ($urandom_range(0, 6) == 0) MODE_BTN = ~MODE_BTN;
      @(negedge CLK);
    end
    repeat (3) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_lab.md
# gate_lab

Parametrised successor to the two-button gate demonstrator: a WIDTH-bit bitwise logic unit whose function (NAND/NOT/AND/OR/XOR) is selected at run time by a debounced mode button. Results drive LEDs through a programmable-duty PWM dimmer. Sits directly under the board top; operands come from buttons or switches, outputs go to LED pins.

## Interface
- WIDTH, 2: operand and result width in bits, minimum 1.
- DB_CYCLES, 65536: consecutive stable cycles required to accept a new mode-button level, minimum 2.
- PWM_BITS, 8: width of the PWM counter and the DUTY input.
- CLK  in  1  system clock; all state on posedge.
- RST_N  in  1  asynchronous active-low reset. Assertion is asynchronous; deassertion is sampled on CLK.
- A  in  WIDTH  operand A, asynchronous to CLK.
- B  in  WIDTH  operand B, asynchronous to CLK. Ignored in NOT mode.
- MODE_BTN  in  1  mode-advance button, active-high, bouncy.
- DUTY  in  PWM_BITS  LED on-time in counts out of 2^PWM_BITS; quasi-static.
- LED  out  WIDTH  dimmed result.
- MODE  out  3  current mode code, undimmed.

## Operation
- A, B and MODE_BTN each pass through a 2-flop synchroniser. Synchroniser reset value is 0.
- Debouncer:
  - Holds a `stable` level and a counter.
  - When the synced input equals `stable`, the counter clears.
  - On the DB_CYCLES-th consecutive cycle in which the synced input differs from `stable`, `stable` takes the synced value and the counter clears.
- A rising edge of `stable` (registered previous vs current) advances the mode by one.
- Falling edges and held presses do nothing.
- Mode codes:
  - 0 NAND, 1 NOT(A), 2 AND, 3 OR, 4 XOR.
  - Mode 4 wraps to 0.
  - Codes 5–7 are never entered. If one is reached (e.g. by an SEU), the unit computes NAND and the next advance goes to 0.
- `result_q` is a register holding op(mode, A_sync, B_sync), applied bitwise across WIDTH bits.
- PWM:
  - `pwm_cnt` is a free-running PWM_BITS counter that wraps from all-ones to 0.
  - `pwm_on` = (pwm_cnt < DUTY).
  - DUTY = 0 gives LED always 0. The maximum DUTY gives on-time of 2^PWM_BITS−1 out of 2^PWM_BITS.
- LED is a register holding result_q AND {WIDTH{pwm_on}}.
- MODE equals the mode register directly.
- Reset values:
  - Mode = 0 (NAND), MODE = 0.
  - LED = 0, result_q = 0, pwm_cnt = 0.
  - Debouncer `stable` = 0, counter = 0, edge register = 0.
- Reset mid-debounce discards the partial count. A button still held when reset is released must be stable for DB_CYCLES cycles and then produces exactly one advance.

## Timing
- Operand path: a change on A/B is visible in result_q 3 edges later (2 sync + 1 reg), and on LED 4 edges later when pwm_on.
- Mode path: after a clean press edge, `stable` rises at edge DB_CYCLES+2 and MODE updates at edge DB_CYCLES+3. result_q reflects the new op one edge after that.
- Mode change and operand change in the same cycle: result_q uses the registered mode value of that cycle, so there is no glitch combination.
- Bounce shorter than DB_CYCLES cycles produces no advance.
- PWM period is 2^PWM_BITS cycles. The first on-window starts at pwm_cnt = 0, one edge after reset release.

## Configuration
- GATE_LAB_XNOR_EN
  - Defined: adds mode 5 = XNOR. The wrap point becomes 5→0, and only codes 6–7 are illegal.
  - Undefined: five modes as above, and 4 wraps to 0.

## Structure
- Package gate_lab_pkg holds:
  - mode enum (MODE_NAND … MODE_XOR, MODE_XNOR under the macro);
  - MODE_W = 3;
  - MODE_LAST constant selected by the macro.
- Sub-module btn_debounce covers the synchroniser, debounce counter and rising-edge pulse. It is parametrised by DB_CYCLES, has ports CLK/RST_N/in/level/rise, and is reusable for future button inputs.
- The gate function is a case on mode inside gate_lab, with no further hierarchy.

## Test plan
Unless a scenario says otherwise, use WIDTH=2, DB_CYCLES=4, PWM_BITS=4 and DUTY=15.
- Reset: hold RST_N=0 with A=3, B=3 and MODE_BTN=1. LED=0 and MODE=0 while in reset. After release with the button held, MODE goes 0→1 exactly once, at edge 7.
- Truth table: for each mode, sweep A,B ∈ {0..3}. With mode XOR, A=2, B=3, LED sampled when pwm_on = 1. With NOT, A=1 gives LED=2 regardless of B.
- Bounce: toggle MODE_BTN every 2 cycles for 20 cycles, then hold at 1. MODE advances once, 7 edges after the final rise.
- Wrap: five clean presses take MODE through 1, 2, 3, 4, 0. With GATE_LAB_XNOR_EN, six presses reach 0 and mode 5 with A=1, B=1 gives LED=3.
- PWM: DUTY=0 gives LED always 0. DUTY=4 with result 3 gives LED=3 for exactly 4 of every 16 cycles. DUTY=15 gives LED=3 for 15 of every 16.
- Mid-operation reset: pulse RST_N low while MODE=3 and the debounce counter is at 2. MODE=0 and LED=0 immediately, and no spurious advance follows.
